// File: rtl/flag_request_ctl.sv
// flag_request_ctl: turns a right-button press on the board into one
// flag-toggle request with 1-based field indices. Pixel offsets are divided
// by the field size through repeated subtraction, one step per cycle.
module flag_request_ctl #(
  parameter int PIX_W = 12,
  parameter int IND_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       level,
  input  logic             game_en,
  input  logic             right,
  input  logic [PIX_W-1:0] xpos,
  input  logic [PIX_W-1:0] ypos,
  input  logic [PIX_W-1:0] board_xpos,
  input  logic [PIX_W-1:0] board_ypos,
  input  logic [5:0]       field_size,
  output logic             mark_flag,
  output logic [IND_W-1:0] flag_ind_x,
  output logic [IND_W-1:0] flag_ind_y,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIV_X    = 3'd1,
    DIV_Y    = 3'd2,
    ISSUE    = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  state_t           state_q;
  logic             right_q;      // previous cycle's button level
  logic             mark_q;
  logic             busy_q;
  logic [IND_W-1:0] ind_x_q, ind_y_q;
  logic [IND_W-1:0] cnt_x_q, cnt_y_q;
  logic [IND_W-1:0] bsz_q;
  logic [5:0]       fs_q;
  logic [PIX_W-1:0] rem_x_q, rem_y_q;

  logic             rise;
  logic [IND_W-1:0] bsz_d;
  logic [PIX_W-1:0] fs_ext;
  logic [IND_W-1:0] cnt_x_inc, cnt_y_inc;

  assign rise      = right & ~right_q;
  assign fs_ext    = PIX_W'(fs_q);
  assign cnt_x_inc = cnt_x_q + IND_W'(1);
  assign cnt_y_inc = cnt_y_q + IND_W'(1);

  // Board edge length for the current level, captured at click time
  always_comb begin
    bsz_d = IND_W'(8);
    case (level)
      2'd3:    bsz_d = IND_W'(16);
      2'd2:    bsz_d = IND_W'(10);
      default: bsz_d = IND_W'(8);
    endcase
  end

  // Request FSM: latch click, divide x then y, issue one pulse, wait release
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      right_q <= 1'b0;
      mark_q  <= 1'b0;
      busy_q  <= 1'b0;
      ind_x_q <= '0;
      ind_y_q <= '0;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      bsz_q   <= '0;
      fs_q    <= '0;
      rem_x_q <= '0;
      rem_y_q <= '0;
    end else begin
      right_q <= right;
      mark_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise && game_en) begin
            bsz_q  <= bsz_d;
            fs_q   <= field_size;
            busy_q <= 1'b1;
            if ((xpos < board_xpos) || (ypos < board_ypos) || (field_size == 6'd0)) begin
              state_q <= WAIT_REL;
            end else begin
              rem_x_q <= xpos - board_xpos;
              rem_y_q <= ypos - board_ypos;
              cnt_x_q <= '0;
              cnt_y_q <= '0;
              state_q <= DIV_X;
            end
          end
        end
        DIV_X: begin
          if (!game_en) begin
            state_q <= WAIT_REL;
          end else if (rem_x_q >= fs_ext) begin
            // a pixel exactly on a boundary belongs to the higher field
            rem_x_q <= rem_x_q - fs_ext;
            cnt_x_q <= cnt_x_inc;
            if (cnt_x_inc == bsz_q) state_q <= WAIT_REL;
          end else begin
            state_q <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (!game_en) begin
            state_q <= WAIT_REL;
          end else if (rem_y_q >= fs_ext) begin
            rem_y_q <= rem_y_q - fs_ext;
            cnt_y_q <= cnt_y_inc;
            if (cnt_y_inc == bsz_q) state_q <= WAIT_REL;
          end else begin
            // outputs are registered here so they are valid during ISSUE
            mark_q  <= 1'b1;
            ind_x_q <= cnt_x_inc;
            ind_y_q <= cnt_y_inc;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!right) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mark_flag  = mark_q;
  assign flag_ind_x = ind_x_q;
  assign flag_ind_y = ind_y_q;
  assign busy       = busy_q;

endmodule
